// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single Data_Memory port: round-robin with an optional
// port-1 burst lock, single outstanding transaction, req/ack handshake.
module dmem_arbiter #(
  parameter int RD_LAT   = 0,
  parameter int MAX_LOCK = 4
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        p0_req,
  input  logic        p0_wr,
  input  logic [31:0] p0_adr,
  input  logic [31:0] p0_wd,
  output logic        p0_ack,
  output logic [31:0] p0_rd,
  input  logic        p1_req,
  input  logic        p1_wr,
  input  logic [31:0] p1_adr,
  input  logic [31:0] p1_wd,
  output logic        p1_ack,
  output logic [31:0] p1_rd,
  input  logic        p1_lock,
  output logic [31:0] m_adr,
  output logic [31:0] m_wd,
  output logic        m_mwr,
  output logic        m_moe,
  input  logic [31:0] m_rd,
  output logic        busy,
  output logic        owner
);

  localparam int          CW        = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned WAIT_INIT = (RD_LAT > 0) ? RD_LAT - 1 : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_owner;
  logic          r_rr_last;
  logic          r_wr;
  logic [31:0]   r_adr;
  logic [31:0]   r_wd;
  logic [31:0]   r_p0_rd;
  logic [31:0]   r_p1_rd;
  logic [3:0]    r_lock_cnt;
  logic [3:0]    w_lock_cnt_nxt;
  logic [CW-1:0] r_wait_cnt;
  logic          w_any_req;
  logic          w_win;
  logic          w_sample;

  assign w_any_req = p0_req | p1_req;

  // Winner selection; a contended locked port-1 grant counts toward MAX_LOCK.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_win          = ~r_rr_last;
    w_lock_cnt_nxt = r_lock_cnt;
    if (p0_req && !p1_req) begin
      w_win = 1'b0;
    end else if (!p0_req && p1_req) begin
      w_win = 1'b1;
    end else if (r_rr_last && p1_lock && (r_lock_cnt < 4'(MAX_LOCK))) begin
      w_win = 1'b1;
    end
    if (!w_win) begin
      w_lock_cnt_nxt = '0;
    end else if (p0_req && p1_lock && (r_lock_cnt < 4'(MAX_LOCK))) begin
      w_lock_cnt_nxt = r_lock_cnt + 4'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sample    = 1'b0;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (r_wr) begin
          w_state_nxt = S_RESP;
        end else if (RD_LAT == 0) begin
          w_sample    = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_sample    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_rr_last  <= 1'b1;
      r_wr       <= 1'b0;
      r_adr      <= '0;
      r_wd       <= '0;
      r_p0_rd    <= '0;
      r_p1_rd    <= '0;
      r_lock_cnt <= '0;
      r_wait_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_any_req) begin
        r_owner    <= w_win;
        r_rr_last  <= w_win;
        r_lock_cnt <= w_lock_cnt_nxt;
        r_wr       <= w_win ? p1_wr  : p0_wr;
        r_adr      <= w_win ? p1_adr : p0_adr;
        r_wd       <= w_win ? p1_wd  : p0_wd;
      end
      if (r_state == S_ISSUE) begin
        r_wait_cnt <= CW'(WAIT_INIT);
      end else if (r_state == S_WAIT && r_wait_cnt != '0) begin
        r_wait_cnt <= r_wait_cnt - 1'b1;
      end
      if (w_sample) begin
        if (r_owner) r_p1_rd <= m_rd;
        else         r_p0_rd <= m_rd;
      end
    end
  end

  // Strobes decode the state register, so RESET drops them without a clock edge.
  assign m_mwr  = (r_state == S_ISSUE) & r_wr;
  assign m_moe  = ((r_state == S_ISSUE) | (r_state == S_WAIT)) & ~r_wr;
  assign m_adr  = r_adr;
  assign m_wd   = r_wd;
  assign p0_ack = (r_state == S_RESP) & ~r_owner;
  assign p1_ack = (r_state == S_RESP) &  r_owner;
  assign p0_rd  = r_p0_rd;
  assign p1_rd  = r_p1_rd;
  assign busy   = (r_state != S_IDLE);
  assign owner  = r_owner;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: dut0 uses RD_LAT=0, dut2 uses RD_LAT=2; both
// share one memory model. Expected acks are queued by stimulus and popped by monitors.
module tb_dmem_arbiter;

  typedef struct {
    logic        port;
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  logic clk;
  logic RESET;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  // dut0 signals
  logic        p0_req0, p0_wr0, p0_ack0, p1_req0, p1_wr0, p1_ack0, p1_lock0;
  logic [31:0] p0_adr0, p0_wd0, p0_rd0, p1_adr0, p1_wd0, p1_rd0;
  logic [31:0] m_adr0, m_wd0, m_rd0;
  logic        m_mwr0, m_moe0, busy0, owner0;
  // dut2 signals
  logic        p0_req2, p0_wr2, p0_ack2, p1_req2, p1_wr2, p1_ack2, p1_lock2;
  logic [31:0] p0_adr2, p0_wd2, p0_rd2, p1_adr2, p1_wd2, p1_rd2;
  logic [31:0] m_adr2, m_wd2, m_rd2;
  logic        m_mwr2, m_moe2, busy2, owner2;

  logic [31:0] mem [256];
  logic        ld_en;
  logic [7:0]  ld_idx;
  logic [31:0] ld_dat;
  int          moe_cnt2 = 0;
  int          mwr0_cycles = 0;
  int          moe2_cycles = 0;

  exp_t        q0[$];
  exp_t        q2[$];
  logic [31:0] em [2][2];

  localparam logic [31:0] DA = 32'hA0A0_0001;
  localparam logic [31:0] DB = 32'hB1B1_0002;
  bit          lock_seq [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0]  ld_tab_idx [7] = '{8'd16, 8'd64, 8'd65, 8'd32, 8'd128, 8'd129, 8'd130};
  logic [31:0] ld_tab_dat [7] = '{32'hDEAD_BEEF, DA, DB, 32'h0, 32'hCAFE_F00D,
                                  32'h5A5A_5A5A, 32'h0102_0304};

  dmem_arbiter #(.RD_LAT(0), .MAX_LOCK(4)) dut0 (
    .clk(clk), .RESET(RESET),
    .p0_req(p0_req0), .p0_wr(p0_wr0), .p0_adr(p0_adr0), .p0_wd(p0_wd0),
    .p0_ack(p0_ack0), .p0_rd(p0_rd0),
    .p1_req(p1_req0), .p1_wr(p1_wr0), .p1_adr(p1_adr0), .p1_wd(p1_wd0),
    .p1_ack(p1_ack0), .p1_rd(p1_rd0), .p1_lock(p1_lock0),
    .m_adr(m_adr0), .m_wd(m_wd0), .m_mwr(m_mwr0), .m_moe(m_moe0), .m_rd(m_rd0),
    .busy(busy0), .owner(owner0)
  );

  dmem_arbiter #(.RD_LAT(2), .MAX_LOCK(4)) dut2 (
    .clk(clk), .RESET(RESET),
    .p0_req(p0_req2), .p0_wr(p0_wr2), .p0_adr(p0_adr2), .p0_wd(p0_wd2),
    .p0_ack(p0_ack2), .p0_rd(p0_rd2),
    .p1_req(p1_req2), .p1_wr(p1_wr2), .p1_adr(p1_adr2), .p1_wd(p1_wd2),
    .p1_ack(p1_ack2), .p1_rd(p1_rd2), .p1_lock(p1_lock2),
    .m_adr(m_adr2), .m_wd(m_wd2), .m_mwr(m_mwr2), .m_moe(m_moe2), .m_rd(m_rd2),
    .busy(busy2), .owner(owner2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: combinational read for dut0; dut2 only sees valid data in its 3rd MOE cycle.
  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_idx] <= ld_dat;
    end else begin
      if (m_mwr0) mem[m_adr0[9:2]] <= m_wd0;
      if (m_mwr2) mem[m_adr2[9:2]] <= m_wd2;
    end
    moe_cnt2 <= m_moe2 ? moe_cnt2 + 1 : 0;
  end
  assign m_rd0 = mem[m_adr0[9:2]];
  assign m_rd2 = (m_moe2 && moe_cnt2 == 2) ? mem[m_adr2[9:2]] : 32'hBAD0_BAD0;

  always @(negedge clk) begin
    if (m_mwr0) mwr0_cycles <= mwr0_cycles + 1;
    if (m_moe2) moe2_cycles <= moe2_cycles + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: got unexpected event expected none (cycle %0d)", name, cyc);
  endtask

  // Monitors: pop and compare whenever a DUT presents an ack.
  always @(negedge clk) begin
    exp_t e;
    if (!RESET && (p0_ack0 || p1_ack0)) begin
      check("dut0 ack exclusive", {31'b0, p0_ack0 & p1_ack0}, 32'd0);
      if (q0.size() == 0) begin
        fail_now("dut0 unexpected ack");
      end else begin
        e = q0.pop_front();
        check("dut0 ack port", {31'b0, p1_ack0}, {31'b0, e.port});
        check("dut0 rd", p1_ack0 ? p1_rd0 : p0_rd0, e.rd);
        check("dut0 ack cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!RESET && (p0_ack2 || p1_ack2)) begin
      check("dut2 ack exclusive", {31'b0, p0_ack2 & p1_ack2}, 32'd0);
      if (q2.size() == 0) begin
        fail_now("dut2 unexpected ack");
      end else begin
        e = q2.pop_front();
        check("dut2 ack port", {31'b0, p1_ack2}, {31'b0, e.port});
        check("dut2 rd", p1_ack2 ? p1_rd2 : p0_rd2, e.rd);
        check("dut2 ack cycle", cyc, e.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input bit port, input bit req, input bit wr,
                       input logic [31:0] adr, input logic [31:0] wd);
    if (d == 0 && !port) begin
      p0_req0 = req; p0_wr0 = wr; p0_adr0 = adr; p0_wd0 = wd;
    end else if (d == 0) begin
      p1_req0 = req; p1_wr0 = wr; p1_adr0 = adr; p1_wd0 = wd;
    end else if (!port) begin
      p0_req2 = req; p0_wr2 = wr; p0_adr2 = adr; p0_wd2 = wd;
    end else begin
      p1_req2 = req; p1_wr2 = wr; p1_adr2 = adr; p1_wd2 = wd;
    end
  endtask

  task automatic push(input int d, input bit port, input logic [31:0] rd, input int c);
    exp_t e;
    e.port = port;
    e.rd   = rd;
    e.cyc  = c;
    if (d == 0) q0.push_back(e);
    else        q2.push_back(e);
  endtask

  // One isolated transaction from IDLE; rd_mem is the hand-computed memory contents.
  task automatic xact(input int d, input bit port, input bit wr, input logic [31:0] adr,
                      input logic [31:0] wd, input logic [31:0] rd_mem);
    int lat;
    int di;
    lat = (d == 2 && !wr) ? 2 : 0;
    di  = (d == 2) ? 1 : 0;
    if (!wr) em[di][port] = rd_mem;
    push(d, port, em[di][port], cyc + 2 + lat);
    drive(d, port, 1'b1, wr, adr, wd);
    repeat (2 + lat) step();
    drive(d, port, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    em = '{default: '0};
    step();
  endtask

  initial begin
    int k;
    int base;
    RESET = 1'b1;
    ld_en = 1'b0; ld_idx = '0; ld_dat = '0;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(2, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    p1_lock0 = 1'b0;
    p1_lock2 = 1'b0;
    em = '{default: '0};
    step();
    ld_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ld_idx = ld_tab_idx[i];
      ld_dat = ld_tab_dat[i];
      step();
    end
    ld_en = 1'b0;

    // Reset state
    check("rst dut0 strobes", {26'b0, p0_ack0, p1_ack0, m_mwr0, m_moe0, busy0, owner0}, 32'd0);
    check("rst dut0 p0_rd", p0_rd0, 32'd0);
    check("rst dut0 p1_rd", p1_rd0, 32'd0);
    check("rst dut0 m_adr", m_adr0, 32'd0);
    check("rst dut0 m_wd", m_wd0, 32'd0);
    check("rst dut2 strobes", {26'b0, p0_ack2, p1_ack2, m_mwr2, m_moe2, busy2, owner2}, 32'd0);
    RESET = 1'b0;
    step();

    // Port 0 alone reads 0x40
    xact(0, 1'b0, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF);
    step();

    // Port 1 writes 0x80, port 0 reads it back; one write strobe cycle
    base = mwr0_cycles;
    xact(0, 1'b1, 1'b1, 32'h80, 32'h1234_5678, 32'h0);
    check("dut0 m_mwr cycles", 32'(mwr0_cycles - base), 32'd1);
    xact(0, 1'b0, 1'b0, 32'h80, 32'h0, 32'h1234_5678);
    step();

    // Both hold req, no lock: 0,1,0,1 every 3 cycles
    do_reset();
    k = cyc;
    for (int i = 0; i < 4; i++) push(0, i[0], i[0] ? DB : DA, k + 2 + 3 * i);
    drive(0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0);
    repeat (11) step();
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) step();

    // Lock: after the first port-0 grant, port 1 gets 4 in a row, then port 0
    do_reset();
    k = cyc;
    for (int i = 0; i < 7; i++) push(0, lock_seq[i], lock_seq[i] ? DB : DA, k + 2 + 3 * i);
    drive(0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h104, 32'h0);
    step();
    p1_lock0 = 1'b1;
    repeat (19) step();
    drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    p1_lock0 = 1'b0;
    repeat (3) step();

    // RD_LAT=2 read: MOE for 3 cycles, data only valid in the last WAIT cycle
    base = moe2_cycles;
    xact(2, 1'b0, 1'b0, 32'h200, 32'h0, 32'hCAFE_F00D);
    check("dut2 m_moe cycles", 32'(moe2_cycles - base), 32'd3);
    step();

    // Reset in WAIT of a port-1 read: immediate idle, no ack, port 0 wins next tie
    drive(2, 1'b1, 1'b1, 1'b0, 32'h204, 32'h0);
    repeat (2) step();
    check("dut2 in wait busy", {31'b0, busy2}, 32'd1);
    RESET = 1'b1;
    #1;
    check("dut2 async busy", {31'b0, busy2}, 32'd0);
    check("dut2 async m_moe", {31'b0, m_moe2}, 32'd0);
    check("dut2 async p1_ack", {31'b0, p1_ack2}, 32'd0);
    drive(2, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    RESET = 1'b0;
    em = '{default: '0};
    repeat (3) step();
    k = cyc;
    push(2, 1'b0, 32'h0102_0304, k + 4);
    push(2, 1'b1, 32'h5A5A_5A5A, k + 9);
    drive(2, 1'b0, 1'b1, 1'b0, 32'h208, 32'h0);
    drive(2, 1'b1, 1'b1, 1'b0, 32'h204, 32'h0);
    repeat (9) step();
    drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(2, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) step();

    check("dut0 pending acks", 32'(q0.size()), 32'd0);
    check("dut2 pending acks", 32'(q2.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish by 100000");
    $fatal(1);
  end

endmodule
